// File: rtl/arb_pkg.sv
// Shared constants and types for the round-robin decoder arbiter.
package arb_pkg;

  localparam int unsigned NREQ   = 16;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned HOLD_W = 8;

  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [NREQ-1:0]   req_t;
  typedef logic [HOLD_W-1:0] hold_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request at or after start, with wrap.
module rr_priority_pick
  import arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [IDX_W-1:0]  off;

  // Rotate so start sits at bit 0, find the lowest set bit, then un-rotate.
  always_comb begin
    dbl   = {req, req};
    rot   = dbl[start +: NREQ];
    off   = '0;
    found = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = IDX_W'(i);
      end
    end
    idx = start + off;
  end

endmodule

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter that owns the select/enable of a 4:16 decoder.
// A grant is held until done or request withdrawal, followed by one
// decoder-disabled cycle. Optional forced release after MAX_HOLD cycles
// is enabled by defining ARB_TIMEOUT_EN.
module rr_decoder_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic             done,
  output logic [IDX_W-1:0] sel,
  output logic             dec_en,
  output logic             gnt_valid,
  output logic [NREQ-1:0]  grant,
  output logic             timeout
);

  // Counter saturates at the last cycle a grant may legally be held.
  localparam hold_t HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_t state_q, state_d;
  idx_t       sel_q, sel_d;
  idx_t       last_q, last_d;
  hold_t      hold_q, hold_d;
  logic       dec_en_q, dec_en_d;
  logic       timeout_q, timeout_d;
  req_t       grant_q, grant_d;

  logic       pick_found_c;
  idx_t       pick_idx_c;
  logic       release_c;
  logic       force_c;

  rr_priority_pick u_pick (
    .req   (req),
    .start (last_q + IDX_W'(1)),
    .found (pick_found_c),
    .idx   (pick_idx_c)
  );

  // Normal release: holder signals done or drops its request.
  assign release_c = done | ~req[sel_q];

`ifdef ARB_TIMEOUT_EN
  assign force_c = (hold_q == HOLD_LAST);
`else
  assign force_c = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    last_d    = last_q;
    hold_d    = hold_q;
    dec_en_d  = dec_en_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        dec_en_d = 1'b0;
        hold_d   = '0;
        if (pick_found_c) begin
          sel_d    = pick_idx_c;
          last_d   = pick_idx_c;
          dec_en_d = 1'b1;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        dec_en_d = 1'b1;
        if (release_c || force_c) begin
          dec_en_d  = 1'b0;
          hold_d    = '0;
          state_d   = IDLE;
          timeout_d = force_c & ~release_c;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        dec_en_d = 1'b0;
      end
    endcase
    grant_d = dec_en_d ? (req_t'(1) << sel_d) : '0;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      last_q    <= IDX_W'(NREQ - 1);
      hold_q    <= '0;
      dec_en_q  <= 1'b0;
      timeout_q <= 1'b0;
      grant_q   <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      dec_en_q  <= dec_en_d;
      timeout_q <= timeout_d;
      grant_q   <= grant_d;
    end
  end

  assign sel       = sel_q;
  assign dec_en    = dec_en_q;
  assign gnt_valid = dec_en_q;
  assign grant     = grant_q;
  assign timeout   = timeout_q;

endmodule
